// File: rtl/aligned_ser_pkg.sv
// Shared types and constants for the aligned pair serializer.
package aligned_ser_pkg;

  localparam int unsigned SEQ_W         = 8;
  localparam int unsigned DROP_CNT_W    = 16;
  localparam int unsigned PAIR_DATA_W   = 32;
  localparam int unsigned PAIR_STATUS_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    W1ST = 2'd2,
    W2D  = 2'd3
  } ser_state_t;

  typedef struct packed {
    logic [PAIR_DATA_W-1:0]   data_1st;
    logic [PAIR_DATA_W-1:0]   data_2d;
    logic [PAIR_STATUS_W-1:0] statuses;
  } ser_pair_t;

endpackage

// File: rtl/ser_pair_fifo.sv
// Synchronous pair FIFO; a push is accepted at full when a pop completes in the same cycle.
module ser_pair_fifo
  import aligned_ser_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   push,
  input  logic                   pop,
  input  ser_pair_t              din,
  output ser_pair_t              head,
  output ser_pair_t              head_next,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  ser_pair_t       mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty     = (level == '0);
  assign full      = (level == LW'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head      = mem[rd_ptr];
  assign head_next = mem[rd_ptr + AW'(1)];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/aligned_pair_serializer.sv
// Buffers aligned pairs and serializes each into a 1st/2d word frame on a valid/ready stream.
// Define ALIGNED_PAIR_SER_HDR_EN to prefix each frame with a {statuses, seq} header word.
module aligned_pair_serializer
  import aligned_ser_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned STATUS_W = 4
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic [WIDTH-1:0]       data_1st_i,
  input  logic [WIDTH-1:0]       data_2d_i,
  input  logic                   vld_i,
  input  logic [STATUS_W-1:0]    statuses_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   vld_o,
  input  logic                   rdy_i,
  output logic                   first_o,
  output logic                   last_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o,
  output logic [DROP_CNT_W-1:0]  drop_cnt_o
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  ser_state_t       state;
  ser_state_t       state_nxt;
  ser_pair_t        in_pair;
  ser_pair_t        head;
  ser_pair_t        head_next;
  ser_pair_t        nxt_pair;
  logic             full;
  logic             empty;
  logic             xfer;
  logic             pop;
  logic             more;
  logic             drop;
  logic [WIDTH-1:0] data_nxt;
  logic             vld_nxt;
  logic             first_nxt;
  logic             last_nxt;

  always_comb begin
    in_pair.data_1st = PAIR_DATA_W'(data_1st_i);
    in_pair.data_2d  = PAIR_DATA_W'(data_2d_i);
    in_pair.statuses = PAIR_STATUS_W'(statuses_i);
  end

  assign xfer = vld_o && rdy_i;
  assign pop  = (state == W2D) && xfer;
  assign drop = vld_i && full && !pop;

  // Next frame source when the 2d word leaves: the following entry, or the pair arriving now.
  assign more     = (level_o > LW'(1)) || vld_i;
  assign nxt_pair = (level_o > LW'(1)) ? head_next : in_pair;

  ser_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .areset    (areset),
    .push      (vld_i),
    .pop       (pop),
    .din       (in_pair),
    .head      (head),
    .head_next (head_next),
    .full      (full),
    .empty     (empty),
    .level     (level_o)
  );

`ifdef ALIGNED_PAIR_SER_HDR_EN
  logic [SEQ_W-1:0] seq;

  function automatic logic [WIDTH-1:0] hdr_word(input logic [PAIR_STATUS_W-1:0] st,
                                                input logic [SEQ_W-1:0] s);
    return WIDTH'({st, s});
  endfunction

  always_ff @(posedge clk or posedge areset) begin
    if (areset)                   seq <= '0;
    else if (state == HDR && xfer) seq <= seq + SEQ_W'(1);
  end
`else
  logic unused_status;
  assign unused_status = ^{head.statuses, nxt_pair.statuses};
`endif

  // Next state and next output word; outputs hold while the current word is not taken.
  always_comb begin
    state_nxt = state;
    data_nxt  = data_o;
    vld_nxt   = vld_o;
    first_nxt = first_o;
    last_nxt  = last_o;
    case (state)
      IDLE: begin
        if (!empty) begin
          vld_nxt   = 1'b1;
          first_nxt = 1'b1;
          last_nxt  = 1'b0;
`ifdef ALIGNED_PAIR_SER_HDR_EN
          state_nxt = HDR;
          data_nxt  = hdr_word(head.statuses, seq);
`else
          state_nxt = W1ST;
          data_nxt  = WIDTH'(head.data_1st);
`endif
        end
      end
`ifdef ALIGNED_PAIR_SER_HDR_EN
      HDR: begin
        if (xfer) begin
          state_nxt = W1ST;
          data_nxt  = WIDTH'(head.data_1st);
          first_nxt = 1'b0;
          last_nxt  = 1'b0;
        end
      end
`endif
      W1ST: begin
        if (xfer) begin
          state_nxt = W2D;
          data_nxt  = WIDTH'(head.data_2d);
          first_nxt = 1'b0;
          last_nxt  = 1'b1;
        end
      end
      W2D: begin
        if (xfer) begin
          if (more) begin
            first_nxt = 1'b1;
            last_nxt  = 1'b0;
`ifdef ALIGNED_PAIR_SER_HDR_EN
            state_nxt = HDR;
            data_nxt  = hdr_word(nxt_pair.statuses, seq);
`else
            state_nxt = W1ST;
            data_nxt  = WIDTH'(nxt_pair.data_1st);
`endif
          end else begin
            state_nxt = IDLE;
            vld_nxt   = 1'b0;
            first_nxt = 1'b0;
            last_nxt  = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state   <= IDLE;
      data_o  <= '0;
      vld_o   <= 1'b0;
      first_o <= 1'b0;
      last_o  <= 1'b0;
    end else begin
      state   <= state_nxt;
      data_o  <= data_nxt;
      vld_o   <= vld_nxt;
      first_o <= first_nxt;
      last_o  <= last_nxt;
    end
  end

  // Drop accounting, cleared only by reset.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      overflow_o <= 1'b0;
      drop_cnt_o <= '0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + DROP_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_aligned_pair_serializer.sv
// Directed bench for aligned_pair_serializer with a frame-queue reference model.
module tb_aligned_pair_serializer;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned STATUS_W = 4;
`ifdef ALIGNED_PAIR_SER_HDR_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif
  localparam int FW = HDR_EN ? 3 : 2;

  logic                   clk = 1'b0;
  logic                   areset;
  logic [WIDTH-1:0]       data_1st_i;
  logic [WIDTH-1:0]       data_2d_i;
  logic                   vld_i;
  logic [STATUS_W-1:0]    statuses_i;
  logic [WIDTH-1:0]       data_o;
  logic                   vld_o;
  logic                   rdy_i;
  logic                   first_o;
  logic                   last_o;
  logic [$clog2(DEPTH):0] level_o;
  logic                   overflow_o;
  logic [15:0]            drop_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  aligned_pair_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STATUS_W(STATUS_W)) dut (
    .clk        (clk),
    .areset     (areset),
    .data_1st_i (data_1st_i),
    .data_2d_i  (data_2d_i),
    .vld_i      (vld_i),
    .statuses_i (statuses_i),
    .data_o     (data_o),
    .vld_o      (vld_o),
    .rdy_i      (rdy_i),
    .first_o    (first_o),
    .last_o     (last_o),
    .level_o    (level_o),
    .overflow_o (overflow_o),
    .drop_cnt_o (drop_cnt_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pairs in the buffer and the word stream still owed downstream.
  typedef struct {
    logic [31:0] data;
    logic        first;
    logic        last;
  } word_t;

  word_t       wq[$];
  int          m_level    = 0;
  int          level_prev = 0;
  int          m_drops    = 0;
  bit          m_ovf      = 1'b0;
  int          m_seq      = 0;
  int          hdr_cnt    = 0;
  logic [31:0] last_hdr   = '0;

  always @(negedge clk) begin
    word_t w;
    bit    xfer;
    bit    last_x;
    if (areset) begin
      wq.delete();
      m_level = 0; level_prev = 0; m_drops = 0; m_ovf = 1'b0; m_seq = 0;
      hdr_cnt = 0;
    end else begin
      check("level", 64'(level_o), 64'(m_level));
      check("overflow", 64'(overflow_o), 64'(m_ovf));
      check("drop_cnt", 64'(drop_cnt_o), 64'(m_drops));
      check("vld", 64'(vld_o), 64'(m_level > 0 && level_prev > 0));
      xfer   = vld_o && rdy_i;
      last_x = 1'b0;
      if (vld_o) begin
        check("word_owed", 64'(wq.size() != 0), 64'(1));
        if (wq.size() != 0) begin
          check("data", 64'(data_o), 64'(wq[0].data));
          check("first", 64'(first_o), 64'(wq[0].first));
          check("last", 64'(last_o), 64'(wq[0].last));
          if (xfer) begin
            if (HDR_EN && wq[0].first) begin
              hdr_cnt++;
              last_hdr = data_o;
            end
            last_x = wq[0].last;
            void'(wq.pop_front());
          end
        end
      end
      level_prev = m_level;
      if (vld_i) begin
        if (m_level < DEPTH || last_x) begin
          m_level++;
          if (HDR_EN) begin
            w.data = (32'(statuses_i) << 8) | 32'(m_seq);
            w.first = 1'b1; w.last = 1'b0;
            wq.push_back(w);
            m_seq = (m_seq + 1) % 256;
          end
          w.data = data_1st_i; w.first = !HDR_EN; w.last = 1'b0;
          wq.push_back(w);
          w.data = data_2d_i; w.first = 1'b0; w.last = 1'b1;
          wq.push_back(w);
        end else begin
          m_ovf = 1'b1;
          if (m_drops < 16'hFFFF) m_drops++;
        end
      end
      if (last_x) m_level--;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    vld_i      = 1'b1;
    data_1st_i = a;
    data_2d_i  = b;
    statuses_i = s;
    step();
    vld_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 200 && (level_o != 0 || vld_o); i++) step();
    check(name, 64'(level_o == 0 && !vld_o), 64'(1));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_vld"}, 64'(vld_o), 64'(0));
    check({tag, "_data"}, 64'(data_o), 64'(0));
    check({tag, "_first"}, 64'(first_o), 64'(0));
    check({tag, "_last"}, 64'(last_o), 64'(0));
    check({tag, "_level"}, 64'(level_o), 64'(0));
    check({tag, "_ovf"}, 64'(overflow_o), 64'(0));
    check({tag, "_drops"}, 64'(drop_cnt_o), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    areset = 1'b1; vld_i = 1'b0; rdy_i = 1'b1;
    data_1st_i = '0; data_2d_i = '0; statuses_i = '0;
    step(); step();
    check_reset_values("rst");
    areset = 1'b0;
    step();

    // Single pair, ready held high.
    push_pair(32'hA5A5_0001, 32'h5A5A_0002, 4'h0);
    check("t1_latency_vld", 64'(vld_o), 64'(0));
    check("t1_level", 64'(level_o), 64'(1));
    step();
    if (HDR_EN) begin
      check("t1_hdr", 64'(data_o), 64'(32'h0));
      check("t1_hdr_first", 64'(first_o), 64'(1));
      step();
    end
    check("t1_w1", 64'(data_o), 64'(32'hA5A5_0001));
    check("t1_w1_first", 64'(first_o), 64'(!HDR_EN));
    step();
    check("t1_w2", 64'(data_o), 64'(32'h5A5A_0002));
    check("t1_w2_last", 64'(last_o), 64'(1));
    step();
    check("t1_idle", 64'(vld_o), 64'(0));

    // Stall for five cycles on the first word of a frame.
    rdy_i = 1'b0;
    push_pair(32'h1111_0003, 32'h2222_0004, 4'h0);
    step();
    for (int i = 0; i < 5; i++) begin
      check("t2_hold", 64'(data_o), HDR_EN ? 64'(32'h0000_0001) : 64'(32'h1111_0003));
      step();
    end
    rdy_i = 1'b1;
    wait_idle("t2_drain");

    // Ten pairs into an 8-deep buffer with ready low.
    rdy_i = 1'b0;
    for (int i = 0; i < 10; i++) push_pair(32'h3000_0000 + i, 32'h4000_0000 + i, 4'(i));
    check("t3_level", 64'(level_o), 64'(8));
    check("t3_drops", 64'(drop_cnt_o), 64'(2));
    check("t3_ovf", 64'(overflow_o), 64'(1));
    rdy_i = 1'b1;
    wait_idle("t3_drain");

    // Full buffer: push in the same cycle as the 2d word transfers.
    rdy_i = 1'b0;
    for (int i = 0; i < 8; i++) push_pair(32'h5000_0000 + i, 32'h6000_0000 + i, 4'h1);
    check("t4_full", 64'(level_o), 64'(8));
    rdy_i = 1'b1;
    repeat (FW - 1) step();
    check("t4_at_w2d", 64'(last_o), 64'(1));
    push_pair(32'h7000_0000, 32'h7000_0001, 4'h2);
    rdy_i = 1'b0;
    check("t4_level", 64'(level_o), 64'(8));
    check("t4_drops", 64'(drop_cnt_o), 64'(2));
    rdy_i = 1'b1;
    wait_idle("t4_drain");

    // Sequence number wrap across 257 frames.
    if (HDR_EN) begin
      areset = 1'b1;
      step();
      areset = 1'b0;
      step();
      for (int i = 0; i < 257; i++) begin
        push_pair(32'h8000_0000 + i, 32'h9000_0000 + i, 4'h3);
        step(); step();
      end
      wait_idle("t5_drain");
      check("t5_hdr_cnt", 64'(hdr_cnt), 64'(257));
      check("t5_last_hdr", 64'(last_hdr), 64'(32'h0000_0300));
      check("t5_drops", 64'(drop_cnt_o), 64'(0));
    end

    // Asynchronous reset mid-frame with three pairs buffered.
    rdy_i = 1'b0;
    for (int i = 0; i < 3; i++) push_pair(32'hB000_0000 + i, 32'hB100_0000 + i, 4'h4);
    step();
    check("t6_pre_vld", 64'(vld_o), 64'(1));
    areset = 1'b1;
    #1;
    check_reset_values("t6_async");
    step();
    areset = 1'b0;
    rdy_i  = 1'b1;
    push_pair(32'hC0DE_0001, 32'hC0DE_0002, 4'h5);
    step();
    check("t6_first_word", 64'(data_o), HDR_EN ? 64'(32'h0000_0500) : 64'(32'hC0DE_0001));
    wait_idle("t6_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aligned_pair_serializer.md
# aligned_pair_serializer

Downstream consumer of the aligner FIFO stage. Takes each aligned pair (1st, 2d, statuses) presented on a single `vld_i` pulse and buffers it. It then serializes the pair into a one-word-wide valid/ready stream for the packetizer. The aligner has no backpressure input, so this block absorbs bursts in a pair buffer and counts pairs lost on overflow.

## Interface
- `WIDTH`, 32: data word width; matches aligner `WIDTH_FIFO`.
- `DEPTH`, 8: pair buffer depth; power of two, ≥ 2.
- `STATUS_W`, 4: width of aligner statuses.
- `clk`  in  1  single clock, rising edge.
- `areset`  in  1  asynchronous, active-high reset.
- `data_1st_i`  in  WIDTH  aligned first-stream word.
- `data_2d_i`  in  WIDTH  aligned second-stream word.
- `vld_i`  in  1  pair valid, one cycle per pair; no backpressure.
- `statuses_i`  in  STATUS_W  aligner statuses for this pair.
- `data_o`  out  WIDTH  serialized word.
- `vld_o`  out  1  `data_o` valid.
- `rdy_i`  in  1  downstream ready.
- `first_o`  out  1  word is the first of a pair frame.
- `last_o`  out  1  word is the 2d word, the last of a frame.
- `level_o`  out  $clog2(DEPTH)+1  pairs held in the buffer.
- `overflow_o`  out  1  sticky; set on any dropped pair.
- `drop_cnt_o`  out  16  dropped-pair count; saturates at 0xFFFF.

## Operation
- Push: `vld_i`=1 and buffer not full → the pair {1st, 2d, statuses} is written.
- Push while full → pair dropped, `overflow_o`←1, `drop_cnt_o`+1 (saturating).
- Full with a pop completing in the same cycle → push accepted; no drop.
- Transfer: `vld_o && rdy_i`. While `vld_o`=1 and `rdy_i`=0, `data_o`, `first_o` and `last_o` are held stable.
- FSM states: IDLE, HDR (macro only), W1ST, W2D.
  - IDLE → HDR (macro) or W1ST when buffer not empty.
  - HDR → W1ST on transfer.
  - W1ST → W2D on transfer.
  - W2D → IDLE on transfer if the buffer becomes empty; otherwise → HDR/W1ST directly, with no bubble.
- Head pair pops on transfer of the W2D word.
- `level_o` counts a pair until its 2d word transfers.
- `first_o` is high on the first word of the frame: HDR if the macro is set, else W1ST.
- `overflow_o` and `drop_cnt_o` clear only on reset.

## Timing
- Reset values: `vld_o`=0, `data_o`=0, `first_o`=0, `last_o`=0, `level_o`=0, `overflow_o`=0, `drop_cnt_o`=0; FSM=IDLE; sequence counter=0.
- Latency: pair pushed at edge N → first word has `vld_o`=1 after edge N+1.
- With `rdy_i` held at 1, throughput is 1 word/cycle: 2 cycles per pair, 3 with the macro.
- Sustained `vld_i` every cycle therefore overflows once DEPTH is exhausted. This is expected.
- `areset` mid-frame: output deasserted asynchronously, buffer emptied, partial frame discarded. `overflow_o` and `drop_cnt_o` also cleared.
- Pointers wrap modulo DEPTH; `level_o` reaches DEPTH exactly at full.

## Configuration
- `ALIGNED_PAIR_SER_HDR_EN` defined:
  - Each frame begins with a header word: [7:0] = 8-bit pair sequence number, [8+STATUS_W-1:8] = statuses, rest 0.
  - Sequence number increments per emitted frame and wraps 255→0.
- Not defined:
  - Frame is 2 words (1st, 2d).
  - Statuses are stored but not emitted.
  - No sequence counter is synthesized.

## Structure
- Package `aligned_ser_pkg`:
  - FSM state enum `ser_state_t`.
  - Pair struct `ser_pair_t` {data_1st, data_2d, statuses}.
  - Constants `SEQ_W`=8 and `DROP_CNT_W`=16.
- Sub-module `ser_pair_fifo`:
  - Synchronous FIFO of `ser_pair_t`.
  - Ports: push, pop, full, empty, level.
  - Allows simultaneous push+pop at full.
- The top level holds the FSM, output register and counters.

## Test plan
- Reset, then a single pair (1st=0xA5A5_0001, 2d=0x5A5A_0002), `rdy_i`=1 → words 0xA5A5_0001 (`first_o`) then 0x5A5A_0002 (`last_o`) on consecutive cycles, starting 1 cycle after push.
- `rdy_i`=0 for 5 cycles during W1ST → `data_o` held at 0xA5A5_0001; after `rdy_i` rises, the stream resumes with no duplication or loss.
- DEPTH=8, `rdy_i`=0, 10 pairs pushed → `level_o`=8, `drop_cnt_o`=2, `overflow_o`=1; releasing `rdy_i` drains exactly the first 8 pairs, in order.
- Buffer full, pair push in the same cycle as a W2D transfer → no drop; `level_o` stays 8.
- Macro on, 257 pairs with statuses=0x3 → header words carry seq 0..255 then 0, and statuses 0x3 at [11:8].
- `areset` pulsed mid-frame with 3 pairs buffered → all outputs at reset values immediately; the next pushed pair emits normally.
